// File: rtl/raw_mosaic_pkg.sv
// Shared types and constants for the RGB-to-Bayer re-mosaic path.
package raw_mosaic_pkg;

    localparam int PIX_W = 12;

    localparam int BAYER_RGGB = 0;
    localparam int BAYER_GRBG = 1;
    localparam int BAYER_GBRG = 2;
    localparam int BAYER_BGGR = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_LINE  = 2'd2
    } fsm_state_t;

    // CFA cell codes in RGGB space; both 01 and 10 are green.
    localparam logic [1:0] CFA_R = 2'b00;
    localparam logic [1:0] CFA_B = 2'b11;

    // Each supported order is RGGB shifted by col and/or row, so the
    // origin is simply the XOR mask applied to {row[0], col[0]}.
    function automatic logic [1:0] bayer_origin(input int order);
        case (order)
            BAYER_RGGB: return 2'b00;
            BAYER_GRBG: return 2'b01;
            BAYER_GBRG: return 2'b10;
            BAYER_BGGR: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/bayer_phase_cnt.sv
// Frame/line tracking FSM with saturating column/row counters.
// Reports, per cycle, whether a pixel is accepted and its col/row index.
module bayer_phase_cnt
    import raw_mosaic_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             fval,
    input  logic             lval,
    output logic             accept,
    output logic [CNT_W-1:0] col_idx,
    output logic [CNT_W-1:0] row_idx,
    output logic             frame_start,
    output logic             line_end,
    output fsm_state_t       state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             fval_q;
    logic             lval_q;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Accepted pixel index is the live counter in LINE and (0, row) on line entry.
    always_comb begin
        frame_start = fval & ~fval_q;
        line_end    = (state == ST_LINE) & fval & lval_q & ~lval;
        accept      = 1'b0;
        col_idx     = col;
        row_idx     = row;
        if (fval) begin
            case (state)
                ST_IDLE: begin
                    if (frame_start && lval) begin
                        accept  = 1'b1;
                        col_idx = '0;
                        row_idx = '0;
                    end
                end
                ST_FRAME: begin
                    if (lval) begin
                        accept  = 1'b1;
                        col_idx = '0;
                    end
                end
                ST_LINE: accept = lval;
                default: accept = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= ST_IDLE;
            col    <= '0;
            row    <= '0;
            fval_q <= 1'b0;
            lval_q <= 1'b0;
        end else begin
            fval_q <= fval;
            lval_q <= lval;
            if (!fval) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (frame_start) begin
                            row <= '0;
                            if (lval) begin
                                state <= ST_LINE;
                                col   <= sat_inc('0);
                            end else begin
                                state <= ST_FRAME;
                            end
                        end
                    end
                    ST_FRAME: begin
                        if (lval) begin
                            state <= ST_LINE;
                            col   <= sat_inc('0);
                        end
                    end
                    ST_LINE: begin
                        if (lval) begin
                            col <= sat_inc(col);
                        end else begin
                            state <= ST_FRAME;
                            row   <= sat_inc(row);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/rgb_to_raw_mosaic.sv
// Re-mosaics 12-bit RGB into single-channel Bayer RAW with 1-cycle latency.
// Optional sticky line-length checker enabled by RGB_TO_RAW_LINE_CHECK_EN.
module rgb_to_raw_mosaic
    import raw_mosaic_pkg::*;
#(
    parameter int BAYER_ORDER = 1,
    parameter int H_ACTIVE    = 640,
    parameter int CNT_W       = 12
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             iFVAL,
    input  logic             iLVAL,
    input  logic [11:0]      iR,
    input  logic [11:0]      iG,
    input  logic [11:0]      iB,
    output logic [11:0]      oRAW,
    output logic             oDVAL,
    output logic             oX,
    output logic             oY,
    output logic             oFVAL,
    output logic [CNT_W-1:0] oCOL,
    output logic [CNT_W-1:0] oROW,
    output logic             oLINE_ERR
);

    localparam logic [1:0]       ORIGIN   = bayer_origin(BAYER_ORDER);
    localparam logic [CNT_W-1:0] LINE_LEN = CNT_W'(H_ACTIVE);

    logic             accept;
    logic [CNT_W-1:0] col_idx;
    logic [CNT_W-1:0] row_idx;
    logic             frame_start;
    logic             line_end;
    fsm_state_t       cnt_state;
    logic [1:0]       cfa;
    logic [PIX_W-1:0] pix_sel;

    bayer_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .fval        (iFVAL),
        .lval        (iLVAL),
        .accept      (accept),
        .col_idx     (col_idx),
        .row_idx     (row_idx),
        .frame_start (frame_start),
        .line_end    (line_end),
        .state       (cnt_state)
    );

    always_comb begin
        cfa = {row_idx[0], col_idx[0]} ^ ORIGIN;
        case (cfa)
            CFA_R:   pix_sel = iR;
            CFA_B:   pix_sel = iB;
            default: pix_sel = iG;
        endcase
    end

    // Pixel-qualified outputs hold between accepted pixels.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            oRAW  <= '0;
            oDVAL <= 1'b0;
            oX    <= 1'b0;
            oY    <= 1'b0;
            oFVAL <= 1'b0;
            oCOL  <= '0;
            oROW  <= '0;
        end else begin
            oFVAL <= iFVAL;
            oDVAL <= accept;
            if (accept) begin
                oRAW <= pix_sel;
                oX   <= col_idx[0];
                oY   <= row_idx[0];
                oCOL <= col_idx;
                oROW <= row_idx;
            end
        end
    end

`ifdef RGB_TO_RAW_LINE_CHECK_EN
    logic line_err_q;
    logic cfg_unused;

    assign cfg_unused = ^cnt_state;

    // At a line end col_idx still holds the number of pixels in that line.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            line_err_q <= 1'b0;
            oLINE_ERR  <= 1'b0;
        end else begin
            if (frame_start) begin
                line_err_q <= 1'b0;
            end else if (line_end && (col_idx != LINE_LEN)) begin
                line_err_q <= 1'b1;
            end
            oLINE_ERR <= line_err_q;
        end
    end
`else
    logic cfg_unused;

    assign cfg_unused = ^{cnt_state, frame_start, line_end, LINE_LEN};
    assign oLINE_ERR  = 1'b0;
`endif

endmodule
